sp_row_packer: RTL and testbench

Upstream stage of the sparse processing element: it accepts one CSR feature row as a serial stream of (column index, value) non-zero elements, packs the row into the flattened column-index and value buses, and issues it to the PE with a single-cycle `pe_valid` pulse. It then holds the issued row stable until the PE's `pe_ready` pulse reports that the dot product has been reduced.

---
 rtl/sp_row_packer.sv | 186 ++++++++++++++++++
 tb/tb_sp_row_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_row_packer.sv
// Packs a serial CSR row of (col, value) elements into flat PE buses and issues it with a one-cycle pe_valid_o pulse.
// Define SP_ROW_PACKER_DBUF_EN for ping-pong buffering: the next row is collected while the issued row awaits pe_ready_i.
module sp_row_packer #(
  parameter  int DATA_WIDTH       = 8,
  parameter  int DOT_PRODUCT_SIZE = 5,
  localparam int COL_IDX_WIDTH    = $clog2(DOT_PRODUCT_SIZE),
  localparam int NODE_INFO_WIDTH  = $clog2(DOT_PRODUCT_SIZE) + 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      elem_valid_i,
  input  logic [COL_IDX_WIDTH-1:0]                  elem_col_idx_i,
  input  logic [DATA_WIDTH-1:0]                     elem_value_i,
  input  logic                                      elem_last_i,
  output logic                                      elem_ready_o,
  output logic                                      pe_valid_o,
  output logic [DOT_PRODUCT_SIZE*COL_IDX_WIDTH-1:0] col_idx_o,
  output logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0]    value_o,
  output logic [NODE_INFO_WIDTH-1:0]                node_info_o,
  input  logic                                      pe_ready_i,
  output logic [15:0]                               rows_issued_o
);
  localparam int CW    = DOT_PRODUCT_SIZE * COL_IDX_WIDTH;
  localparam int VW    = DOT_PRODUCT_SIZE * DATA_WIDTH;
  // Wide enough to hold DOT_PRODUCT_SIZE even when it is a power of two.
  localparam int CNT_W = $clog2(DOT_PRODUCT_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DOT_PRODUCT_SIZE);

  typedef enum logic [1:0] {S_COLLECT, S_ISSUE, S_WAIT} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]              buf_col_q, buf_col_d;
  logic [VW-1:0]              buf_val_q, buf_val_d;
  logic [CNT_W-1:0]           buf_cnt_q, buf_cnt_d;
  logic                       buf_ovf_q, buf_ovf_d;
  logic [CW-1:0]              col_q;
  logic [VW-1:0]              val_q;
  logic [NODE_INFO_WIDTH-1:0] ninfo_q;
  logic [15:0]                rows_issued_q;
  logic                       accept, row_done, load_out, load_from_buf, clr_buf;
  logic [CNT_W-1:0]           sel_cnt;
  logic                       sel_ovf;
`ifdef SP_ROW_PACKER_DBUF_EN
  logic                       full_q, full_d;
`endif

  assign accept   = elem_valid_i && elem_ready_o;
  assign row_done = accept && elem_last_i;

  // Collection buffer with the current element merged in; extra elements only raise overflow.
  always_comb begin
    buf_col_d = buf_col_q;
    buf_val_d = buf_val_q;
    buf_cnt_d = buf_cnt_q;
    buf_ovf_d = buf_ovf_q;
    if (accept) begin
      if (buf_cnt_q < CNT_MAX) begin
        for (int s = 0; s < DOT_PRODUCT_SIZE; s++) begin
          if (s == DOT_PRODUCT_SIZE - 1 - int'(buf_cnt_q)) begin
            buf_col_d[s*COL_IDX_WIDTH +: COL_IDX_WIDTH] = elem_col_idx_i;
            buf_val_d[s*DATA_WIDTH +: DATA_WIDTH]       = elem_value_i;
          end
        end
        buf_cnt_d = buf_cnt_q + CNT_W'(1);
      end else begin
        buf_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_from_buf = 1'b0;
    clr_buf       = 1'b0;
`ifdef SP_ROW_PACKER_DBUF_EN
    full_d        = full_q;
`endif
    case (state_q)
      S_COLLECT: begin
        if (row_done) begin
          state_d  = S_ISSUE;
          load_out = 1'b1;
          clr_buf  = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef SP_ROW_PACKER_DBUF_EN
        if (row_done) full_d = 1'b1;
`endif
      end
      S_WAIT: begin
`ifdef SP_ROW_PACKER_DBUF_EN
        if (pe_ready_i && full_q) begin
          state_d       = S_ISSUE;
          load_out      = 1'b1;
          load_from_buf = 1'b1;
          clr_buf       = 1'b1;
          full_d        = 1'b0;
        end else if (pe_ready_i && row_done) begin
          state_d  = S_ISSUE;
          load_out = 1'b1;
          clr_buf  = 1'b1;
        end else if (pe_ready_i) begin
          state_d = S_COLLECT;
        end else if (row_done) begin
          full_d = 1'b1;
        end
`else
        if (pe_ready_i) state_d = S_COLLECT;
`endif
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    pe_valid_o = (state_q == S_ISSUE);
`ifdef SP_ROW_PACKER_DBUF_EN
    elem_ready_o = !rst && !full_q;
`else
    elem_ready_o = !rst && (state_q == S_COLLECT);
`endif
  end

  assign sel_cnt = load_from_buf ? buf_cnt_q : buf_cnt_d;
  assign sel_ovf = load_from_buf ? buf_ovf_q : buf_ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_col_q <= '0;
      buf_val_q <= '0;
      buf_cnt_q <= '0;
      buf_ovf_q <= 1'b0;
    end else if (clr_buf) begin
      buf_col_q <= '0;
      buf_val_q <= '0;
      buf_cnt_q <= '0;
      buf_ovf_q <= 1'b0;
    end else begin
      buf_col_q <= buf_col_d;
      buf_val_q <= buf_val_d;
      buf_cnt_q <= buf_cnt_d;
      buf_ovf_q <= buf_ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q         <= '0;
      val_q         <= '0;
      ninfo_q       <= '0;
      rows_issued_q <= '0;
    end else if (load_out) begin
      col_q         <= load_from_buf ? buf_col_q : buf_col_d;
      val_q         <= load_from_buf ? buf_val_q : buf_val_d;
      ninfo_q       <= {sel_cnt[NODE_INFO_WIDTH-2:0], sel_ovf};
      rows_issued_q <= rows_issued_q + 16'd1;
    end
  end

`ifdef SP_ROW_PACKER_DBUF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end
`endif

  assign col_idx_o     = col_q;
  assign value_o       = val_q;
  assign node_info_o   = ninfo_q;
  assign rows_issued_o = rows_issued_q;

endmodule

// File: tb/tb_sp_row_packer.sv
// Bench for sp_row_packer: directed and random rows checked against a slot-arithmetic row model.
module tb_sp_row_packer;
  localparam int DW  = 8;
  localparam int DPS = 5;
  localparam int CIW = $clog2(DPS);
  localparam int NIW = $clog2(DPS) + 1;
  localparam int CW  = DPS * CIW;
  localparam int VW  = DPS * DW;
`ifdef SP_ROW_PACKER_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           elem_valid_i = 1'b0;
  logic [CIW-1:0] elem_col_idx_i = '0;
  logic [DW-1:0]  elem_value_i = '0;
  logic           elem_last_i = 1'b0;
  logic           elem_ready_o;
  logic           pe_valid_o;
  logic [CW-1:0]  col_idx_o;
  logic [VW-1:0]  value_o;
  logic [NIW-1:0] node_info_o;
  logic           pe_ready_i = 1'b0;
  logic [15:0]    rows_issued_o;

  sp_row_packer #(.DATA_WIDTH(DW), .DOT_PRODUCT_SIZE(DPS)) dut (
    .clk(clk), .rst(rst),
    .elem_valid_i(elem_valid_i), .elem_col_idx_i(elem_col_idx_i),
    .elem_value_i(elem_value_i), .elem_last_i(elem_last_i),
    .elem_ready_o(elem_ready_o), .pe_valid_o(pe_valid_o),
    .col_idx_o(col_idx_o), .value_o(value_o), .node_info_o(node_info_o),
    .pe_ready_i(pe_ready_i), .rows_issued_o(rows_issued_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ecol[16];
  int evl[16];
  int n_el;
  logic [CW-1:0]  exp_col;
  logic [VW-1:0]  exp_val;
  logic [NIW-1:0] exp_ni;
  logic [15:0]    exp_rows = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_row(input int n);
    n_el = n;
    for (int k = 0; k < n; k++) begin
      ecol[k] = $urandom_range(0, (1 << CIW) - 1);
      evl[k]  = $urandom_range(1, 255);
    end
  endtask

  // Element k lands in slot DPS-1-k; beyond DPS elements only the overflow flag changes.
  task automatic model_row();
    int m;
    m = (n_el < DPS) ? n_el : DPS;
    exp_col = '0;
    exp_val = '0;
    for (int k = 0; k < m; k++) begin
      exp_col = exp_col | (CW'(ecol[k]) << (CIW * (DPS - 1 - k)));
      exp_val = exp_val | (VW'(evl[k]) << (DW * (DPS - 1 - k)));
    end
    exp_ni   = NIW'(m * 2 + ((n_el > DPS) ? 1 : 0));
    exp_rows = exp_rows + 16'd1;
  endtask

  task automatic feed(input logic with_last, input logic noise);
    for (int k = 0; k < n_el; k++) begin
      elem_valid_i   = 1'b1;
      elem_col_idx_i = CIW'(ecol[k]);
      elem_value_i   = DW'(evl[k]);
      elem_last_i    = with_last && (k == n_el - 1);
      pe_ready_i     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("elem_ready", 64'(elem_ready_o), 64'(1'b1));
      tick();
    end
    elem_valid_i = 1'b0;
    elem_last_i  = 1'b0;
    pe_ready_i   = 1'b0;
  endtask

  task automatic issue_check(input string tag);
    chk({tag, ".pe_valid"}, 64'(pe_valid_o), 64'(1'b1));
    chk({tag, ".col_idx"}, 64'(col_idx_o), 64'(exp_col));
    chk({tag, ".value"}, 64'(value_o), 64'(exp_val));
    chk({tag, ".node_info"}, 64'(node_info_o), 64'(exp_ni));
    chk({tag, ".rows"}, 64'(rows_issued_o), 64'(exp_rows));
  endtask

  task automatic hold_check(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      chk("hold.pe_valid", 64'(pe_valid_o), 64'(1'b0));
      chk("hold.ready", 64'(elem_ready_o), 64'(DBUF));
      chk("hold.col_idx", 64'(col_idx_o), 64'(exp_col));
      chk("hold.value", 64'(value_o), 64'(exp_val));
      chk("hold.node_info", 64'(node_info_o), 64'(exp_ni));
    end
  endtask

  task automatic retire();
    pe_ready_i = 1'b1;
    tick();
    pe_ready_i = 1'b0;
    chk("retire.ready", 64'(elem_ready_o), 64'(1'b1));
    chk("retire.pe_valid", 64'(pe_valid_o), 64'(1'b0));
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst.ready", 64'(elem_ready_o), 64'(1'b0));
    chk("rst.pe_valid", 64'(pe_valid_o), 64'(1'b0));
    chk("rst.col_idx", 64'(col_idx_o), 64'(0));
    chk("rst.value", 64'(value_o), 64'(0));
    chk("rst.node_info", 64'(node_info_o), 64'(0));
    chk("rst.rows", 64'(rows_issued_o), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst.ready", 64'(elem_ready_o), 64'(1'b1));
    tick();

    // Directed three-element row.
    n_el = 3;
    ecol[0] = 4; evl[0] = 'h11;
    ecol[1] = 1; evl[1] = 'h22;
    ecol[2] = 0; evl[2] = 'h33;
    model_row();
    feed(1'b1, 1'b0);
    issue_check("row3");
    chk("row3.col_lit", 64'(col_idx_o), 64'(15'h4200));
    chk("row3.val_lit", 64'(value_o), 64'(40'h1122330000));
    chk("row3.ni_lit", 64'(node_info_o), 64'(4'b0110));
    hold_check(20);
    retire();

    // Overflow: seven elements into five slots.
    gen_row(7);
    model_row();
    feed(1'b1, 1'b0);
    issue_check("ovf");
    chk("ovf.ni_lit", 64'(node_info_o), 64'(4'b1011));
    hold_check(1);
    retire();

    // Random rows with spurious pe_ready pulses while collecting.
    for (int r = 0; r < 30; r++) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int i = 0; i < idle; i++) begin
        pe_ready_i = 1'($urandom_range(0, 1));
        tick();
        pe_ready_i = 1'b0;
        chk("idle.ready", 64'(elem_ready_o), 64'(1'b1));
        chk("idle.pe_valid", 64'(pe_valid_o), 64'(1'b0));
      end
      gen_row($urandom_range(1, 8));
      model_row();
      feed(1'b1, 1'b1);
      issue_check("rand");
      hold_check($urandom_range(1, 4));
      retire();
    end

`ifdef SP_ROW_PACKER_DBUF_EN
    // Second row completes during WAIT and issues the cycle after pe_ready_i.
    gen_row(2);
    model_row();
    feed(1'b1, 1'b0);
    issue_check("dbA");
    tick();
    gen_row(3);
    feed(1'b1, 1'b0);
    chk("dbA.full_ready", 64'(elem_ready_o), 64'(1'b0));
    chk("dbA.col_held", 64'(col_idx_o), 64'(exp_col));
    model_row();
    pe_ready_i = 1'b1;
    tick();
    pe_ready_i = 1'b0;
    issue_check("dbB");
    hold_check(1);
    retire();
`endif

    // Reset in the middle of a row discards it and clears all outputs.
    gen_row(2);
    feed(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.col_idx", 64'(col_idx_o), 64'(0));
    chk("midrst.value", 64'(value_o), 64'(0));
    chk("midrst.node_info", 64'(node_info_o), 64'(0));
    chk("midrst.rows", 64'(rows_issued_o), 64'(0));
    chk("midrst.ready", 64'(elem_ready_o), 64'(1'b0));
    tick();
    rst = 1'b0;
    exp_rows = '0;
    tick();
    n_el = 1;
    ecol[0] = 2; evl[0] = 'h05;
    model_row();
    feed(1'b1, 1'b0);
    issue_check("after_rst");
    chk("after_rst.col_lit", 64'(col_idx_o), 64'(15'h2000));
    chk("after_rst.val_lit", 64'(value_o), 64'(40'h0500000000));
    chk("after_rst.ni_lit", 64'(node_info_o), 64'(4'b0010));
    chk("after_rst.rows_lit", 64'(rows_issued_o), 64'(16'd1));
    hold_check(1);
    retire();

    // Counter wrap: preload the count to 0xFFFF, then issue two rows.
    force dut.rows_issued_q = 16'hFFFF;
    tick();
    release dut.rows_issued_q;
    exp_rows = 16'hFFFF;
    for (int r = 0; r < 2; r++) begin
      gen_row(1);
      model_row();
      feed(1'b1, 1'b0);
      issue_check("wrap");
      hold_check(1);
      retire();
    end
    chk("wrap.rows_lit", 64'(rows_issued_o), 64'(16'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
